// File: rtl/mdr_unit_pkg.sv
// mdr_unit shared types: access-size codes, FSM states
// and the byte-enable mask helper.
package mdr_unit_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_WAIT,
    S_DONE
  } state_t;

  // Mask sized for the widest bus (8 lanes); callers truncate.
  function automatic logic [7:0] be_mask(
    input logic [1:0] sz,
    input logic [2:0] off
  );
    logic [7:0] m;
    case (sz)
      SZ_HALF: m = 8'b0000_0011 << off;
      SZ_BYTE: m = 8'b0000_0001 << off;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mdr_unit_if.sv
// Memory port of mdr_unit: request/ack handshake plus data.
// master = MDR side, slave = memory side.
interface mdr_unit_if #(
  parameter int DATA_W = 32
);
  logic                mem_req;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mdr_lane_extract.sv
// Read-path lane select with zero/sign extension.
// i_data/i_size/i_sext/i_off in, o_data extended value out.
module mdr_lane_extract
  import mdr_unit_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int AW     = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_size,
  input  logic              i_sext,
  input  logic [AW-1:0]     i_off,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_sh;
  logic              w_s16;
  logic              w_s8;

  // Word accesses are always at offset 0, so w_sh is the raw word.
  assign w_sh  = i_data >> {i_off, 3'b000};
  assign w_s16 = i_sext & w_sh[15];
  assign w_s8  = i_sext & w_sh[7];

  always_comb begin
    o_data = w_sh;
    case (i_size)
      SZ_HALF: o_data = {{(DATA_W-16){w_s16}}, w_sh[15:0]};
      SZ_BYTE: o_data = {{(DATA_W-8){w_s8}}, w_sh[7:0]};
      default: o_data = w_sh;
    endcase
  end

endmodule

// File: rtl/mdr_unit.sv
// Memory data register with its own req/ack memory handshake.
// Ports: clk, clr (async low), bus/cmd inputs, mem port, Q/busy/done/err.
module mdr_unit
  import mdr_unit_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 15,
  localparam int NB      = DATA_W/8,
  localparam int AW      = $clog2(NB)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [AW-1:0]     addr_lo,
  mdr_unit_if.master        mem,
  output logic [DATA_W-1:0] Q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_q;
  logic              r_req;
  logic              r_we;
  logic [NB-1:0]     r_be;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [AW-1:0]     r_off;

  logic              w_legal;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_rep;
  logic [DATA_W-1:0] w_ext;
  logic [8:0]        w_cnt_nxt;
  logic              w_tmo;

  assign w_legal = (size != SZ_ILL)
                && !(size == SZ_HALF && addr_lo[0])
                && !(size == SZ_WORD && addr_lo != '0);

  assign w_be = NB'(be_mask(size, 3'(addr_lo)));

  always_comb begin
    w_rep = r_q;
    case (size)
      SZ_HALF: w_rep = {(DATA_W/16){r_q[15:0]}};
      SZ_BYTE: w_rep = {(DATA_W/8){r_q[7:0]}};
      default: w_rep = r_q;
    endcase
  end

  // Abort once the request has been up TIMEOUT cycles.
  assign w_cnt_nxt = {1'b0, r_cnt} + 9'd1;
  assign w_tmo     = (w_cnt_nxt == 9'(TIMEOUT));

  mdr_lane_extract #(.DATA_W(DATA_W)) u_ext (
    .i_data (mem.mem_rdata),
    .i_size (r_size),
    .i_sext (r_sext),
    .i_off  (r_off),
    .o_data (w_ext)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= SZ_WORD;
      r_sext  <= 1'b0;
      r_off   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (Read || Write) begin
            r_size <= size;
            r_sext <= sext;
            r_off  <= addr_lo;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_legal) begin
              r_state <= Read ? S_RD_WAIT : S_WR_WAIT;
              r_err   <= 1'b0;
              r_req   <= 1'b1;
              r_we    <= !Read;
              r_be    <= w_be;
              r_wdata <= Read ? '0 : w_rep;
            end else begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
              r_done  <= 1'b1;
            end
          end else if (MDRin) begin
            r_q <= BusMuxOut;
          end
        end
        S_RD_WAIT, S_WR_WAIT: begin
          if (mem.mem_ack || w_tmo) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_done  <= 1'b1;
            r_err   <= !mem.mem_ack;
            if (mem.mem_ack && r_state == S_RD_WAIT)
              r_q <= w_ext;
          end else begin
            r_cnt <= w_cnt_nxt[7:0];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_we;
  assign mem.mem_be    = r_be;
  assign mem.mem_wdata = r_wdata;
  assign Q             = r_q;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule

// File: tb/tb_mdr_unit.sv
// Self-checking bench for mdr_unit (DATA_W=32, TIMEOUT=15)
// with a behavioural load/store reference model.
module tb_mdr_unit;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] bus;
  logic        MDRin, Read, Write;
  logic [1:0]  size;
  logic        sext;
  logic [1:0]  addr_lo;
  logic [31:0] Q;
  logic        busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [31:0] q_model;

  mdr_unit_if #(.DATA_W(32)) mif ();

  mdr_unit #(.DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .clr       (clr),
    .BusMuxOut (bus),
    .MDRin     (MDRin),
    .Read      (Read),
    .Write     (Write),
    .size      (size),
    .sext      (sext),
    .addr_lo   (addr_lo),
    .mem       (mif),
    .Q         (Q),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(
    logic [31:0] d, logic [1:0] sz, logic [1:0] off, logic sx);
    int unsigned bits, v;
    bits = (sz == 2'd0) ? 32 : (sz == 2'd1) ? 16 : 8;
    if (bits == 32) return d;
    v = (d >> (8 * off)) % (32'd1 << bits);
    if (sx && v >= (32'd1 << (bits - 1)))
      v = v - (32'd1 << bits);
    return v;
  endfunction

  function automatic logic [31:0] st_data(logic [31:0] q, logic [1:0] sz);
    if (sz == 2'd1) return (q % 32'h10000) * 32'h0001_0001;
    if (sz == 2'd2) return (q % 32'h100) * 32'h0101_0101;
    return q;
  endfunction

  function automatic logic [3:0] st_be(logic [1:0] sz, logic [1:0] off);
    if (sz == 2'd1) return 4'(32'd3 << off);
    if (sz == 2'd2) return 4'(32'd1 << off);
    return 4'hF;
  endfunction

  task automatic load_q(logic [31:0] v);
    bus = v; MDRin = 1'b1;
    step();
    MDRin = 1'b0; bus = $urandom;
    q_model = v;
    chk("mdrin_q", Q, q_model);
  endtask

  task automatic do_read(logic [1:0] sz, logic [1:0] off, logic sx,
                         logic [31:0] rd, int dly, logic side);
    size = sz; addr_lo = off; sext = sx;
    Read = 1'b1; MDRin = side; Write = side; bus = ~rd;
    step();
    Read = 1'b0; MDRin = 1'b0; Write = 1'b0;
    size = 2'($urandom); addr_lo = 2'($urandom); sext = 1'($urandom);
    chk("rd_req", 32'(mif.mem_req), 1);
    chk("rd_we", 32'(mif.mem_we), 0);
    chk("rd_err_clr", 32'(err), 0);
    repeat (dly) step();
    chk("rd_req_hold", 32'(mif.mem_req), 1);
    mif.mem_ack = 1'b1; mif.mem_rdata = rd;
    step();
    mif.mem_ack = 1'b0; mif.mem_rdata = $urandom;
    q_model = ld_model(rd, sz, off, sx);
    chk("rd_q", Q, q_model);
    chk("rd_done", 32'(done), 1);
    chk("rd_err", 32'(err), 0);
    chk("rd_req_drop", 32'(mif.mem_req), 0);
    step();
    chk("rd_done_pulse", 32'(done), 0);
    chk("rd_busy_low", 32'(busy), 0);
  endtask

  task automatic do_write(logic [1:0] sz, logic [1:0] off, int dly);
    size = sz; addr_lo = off; Write = 1'b1;
    step();
    Write = 1'b0; size = 2'($urandom); addr_lo = 2'($urandom);
    chk("wr_req", 32'(mif.mem_req), 1);
    chk("wr_we", 32'(mif.mem_we), 1);
    chk("wr_be", 32'(mif.mem_be), 32'(st_be(sz, off)));
    chk("wr_wdata", mif.mem_wdata, st_data(q_model, sz));
    repeat (dly) step();
    mif.mem_ack = 1'b1;
    step();
    mif.mem_ack = 1'b0;
    chk("wr_done", 32'(done), 1);
    chk("wr_err", 32'(err), 0);
    chk("wr_q_keep", Q, q_model);
    chk("wr_be_idle", 32'(mif.mem_be), 0);
    chk("wr_wdata_idle", mif.mem_wdata, 0);
    step();
    chk("wr_busy_low", 32'(busy), 0);
  endtask

  task automatic bad_cmd(logic rd, logic [1:0] sz, logic [1:0] off);
    size = sz; addr_lo = off; Read = rd; Write = !rd;
    step();
    Read = 1'b0; Write = 1'b0;
    chk("bad_no_req", 32'(mif.mem_req), 0);
    chk("bad_done", 32'(done), 1);
    chk("bad_err", 32'(err), 1);
    step();
    chk("bad_done_pulse", 32'(done), 0);
    chk("bad_busy_low", 32'(busy), 0);
    chk("bad_err_sticky", 32'(err), 1);
  endtask

  initial begin
    int cnt;
    logic [1:0] sz, off;

    clr = 1'b0; bus = '0; MDRin = 0; Read = 0; Write = 0;
    size = '0; sext = 0; addr_lo = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    q_model = '0;
    #2;
    chk("rst_q", Q, 0);
    chk("rst_req", 32'(mif.mem_req), 0);
    chk("rst_we", 32'(mif.mem_we), 0);
    chk("rst_be", 32'(mif.mem_be), 0);
    chk("rst_wdata", mif.mem_wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    step();
    clr = 1'b1;
    step();

    // Word read, ack in first wait cycle.
    do_read(2'd0, 2'd0, 1'b0, 32'hDEADBEEF, 0, 1'b0);
    chk("word_q", Q, 32'hDEADBEEF);

    // Byte loads, sign and zero extended.
    do_read(2'd2, 2'd2, 1'b1, 32'h0080_0000, 1, 1'b0);
    chk("byte_sx", Q, 32'hFFFFFF80);
    do_read(2'd2, 2'd2, 1'b0, 32'h0080_0000, 0, 1'b0);
    chk("byte_zx", Q, 32'h00000080);
    do_read(2'd1, 2'd2, 1'b1, 32'h8001_7FFF, 2, 1'b0);
    chk("half_sx", Q, 32'hFFFF8001);

    // Half store.
    load_q(32'h0000_1234);
    do_write(2'd1, 2'd2, 0);

    // Timeout: no ack at all.
    load_q(32'h5A5A_1234);
    size = 2'd0; addr_lo = 2'd0; Read = 1'b1;
    step();
    Read = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mif.mem_req) break;
      cnt++;
      step();
    end
    chk("to_req_cycles", cnt, TMO);
    chk("to_done", 32'(done), 1);
    chk("to_err", 32'(err), 1);
    chk("to_q_keep", Q, q_model);
    step();
    chk("to_done_pulse", 32'(done), 0);
    chk("to_err_sticky", 32'(err), 1);

    // Next read clears err; ack on the last permitted cycle wins.
    do_read(2'd0, 2'd0, 1'b0, 32'hCAFE_F00D, TMO - 1, 1'b0);

    // Misaligned and illegal commands.
    bad_cmd(1'b1, 2'd1, 2'd1);
    bad_cmd(1'b1, 2'd0, 2'd2);
    bad_cmd(1'b0, 2'd3, 2'd0);
    chk("bad_q_keep", Q, q_model);

    // Read+MDRin+Write together: read wins.
    do_read(2'd2, 2'd1, 1'b0, 32'h1234_AB56, 0, 1'b1);

    // Commands while busy are ignored.
    size = 2'd0; addr_lo = 2'd0; Read = 1'b1;
    step();
    Read = 1'b0;
    bus = 32'hFFFF_0000; MDRin = 1'b1; Write = 1'b1;
    step();
    MDRin = 1'b0; Write = 1'b0;
    chk("busy_we_ign", 32'(mif.mem_we), 0);
    chk("busy_q_ign", Q, q_model);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0BAD_CAFE;
    step();
    mif.mem_ack = 1'b0;
    q_model = 32'h0BAD_CAFE;
    chk("busy_rd_q", Q, q_model);
    step();

    // Stray ack in IDLE is ignored.
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h7777_7777;
    step();
    mif.mem_ack = 1'b0;
    chk("idle_ack_q", Q, q_model);
    chk("idle_ack_done", 32'(done), 0);
    chk("idle_ack_busy", 32'(busy), 0);

    // Randomised legal traffic.
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 2));
      off = (sz == 2'd0) ? 2'd0 :
            (sz == 2'd1) ? 2'(2 * $urandom_range(0, 1)) :
                           2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_read(sz, off, 1'($urandom), $urandom,
                $urandom_range(0, 4), 1'b0);
      else begin
        load_q($urandom);
        do_write(sz, off, $urandom_range(0, 4));
      end
    end

    // Reset mid-read.
    size = 2'd0; addr_lo = 2'd0; Read = 1'b1;
    step();
    Read = 1'b0;
    step();
    chk("mid_req", 32'(mif.mem_req), 1);
    clr = 1'b0;
    #1;
    q_model = '0;
    chk("mid_rst_req", 32'(mif.mem_req), 0);
    chk("mid_rst_q", Q, q_model);
    chk("mid_rst_done", 32'(done), 0);
    step();
    clr = 1'b1;
    step();
    chk("mid_rel_busy", 32'(busy), 0);
    chk("mid_rel_done", 32'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mdr_unit.md
# mdr_unit

Parametrised memory data register for the Mini-SRC datapath: the next generation of the plain MDR. Besides loading from the bus, it runs its own memory handshake (request/acknowledge with a timeout) and supports word, halfword and byte accesses. Loads are lane-extracted and zero- or sign-extended; stores use lane replication with byte enables. It sits between the internal bus (BusMuxOut in, Q out to the bus mux) and the memory port, and reports busy/done/err to the control unit.

## Interface
- DATA_W, 32, data width; legal values 32 or 64
- TIMEOUT, 15, maximum wait cycles for mem_ack before abort; legal range 1..255
- clk  in  1  clock; all state changes on the rising edge
- clr  in  1  reset, asynchronous, active-low
- BusMuxOut  in  DATA_W  internal bus value
- MDRin  in  1  load Q from BusMuxOut (IDLE only)
- Read  in  1  start memory read (one-cycle pulse)
- Write  in  1  start memory write of Q
- size  in  2  access size: 00 word (DATA_W), 01 half, 10 byte, 11 illegal
- sext  in  1  loads: 1 = sign-extend, 0 = zero-extend
- addr_lo  in  $clog2(DATA_W/8)  byte offset of the access
- mem_rdata  in  DATA_W  memory read data
- mem_ack  in  1  memory acknowledge
- mem_req  out  1  memory request
- mem_we  out  1  1 = write request
- mem_be  out  DATA_W/8  byte enables
- mem_wdata  out  DATA_W  write data
- Q  out  DATA_W  register contents
- busy  out  1  high when not in IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  last operation failed; sticky until the next Read/Write accepted

## Operation
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE, commands accepted, priority Read > Write > MDRin:
  - Read or Write with a legal size and aligned offset: go to RD_WAIT or WR_WAIT, clear err, clear the wait counter.
  - Illegal size, or misaligned offset (half with odd addr_lo; word with addr_lo≠0): go straight to DONE with err=1 and no request.
  - MDRin alone: Q <= BusMuxOut; stay in IDLE; no done pulse.
- RD_WAIT / WR_WAIT:
  - mem_req=1; mem_we=1 only in WR_WAIT.
  - mem_ack=1: go to DONE. In RD_WAIT, Q <= extracted lane of mem_rdata at bits [8·addr_lo +: size], zero- or sign-extended to DATA_W.
  - Otherwise the counter increments. When the counter equals TIMEOUT, go to DONE with err=1 and Q unchanged.
- DONE: done=1 for one cycle, then IDLE. All commands are ignored in DONE.
- Commands (Read, Write, MDRin) arriving while busy are ignored, not queued.
- addr_lo, size and sext are captured on acceptance; they may change afterwards.
- Store data: mem_wdata = low size bits of Q replicated across all lanes. mem_be:
  - word: all ones
  - half: 2'b11 << addr_lo
  - byte: 1 << addr_lo
- mem_be and mem_wdata are driven as zero when mem_req=0.
- Reset values: state IDLE, Q=0, mem_req=0, mem_we=0, mem_be=0, mem_wdata=0, busy=0, done=0, err=0, counter=0.

## Timing
- Command sampled at edge N; mem_req high from N+1.
- mem_ack sampled at edge M: Q valid and done=1 from M+1; busy low from M+2.
- Minimum read latency, Read pulse to done: 2 cycles (ack in first wait cycle).
- Timeout: a request with no ack stays high exactly TIMEOUT cycles; done and err rise the following cycle.
- An ack arriving in the same cycle the counter reaches TIMEOUT counts as success (ack wins).
- mem_ack outside the WAIT states is ignored.
- Reset asserted mid-transfer: mem_req drops immediately (asynchronous); the transfer is abandoned without a done pulse.
- mem_req, mem_we, mem_be, mem_wdata, busy, done and err are all registered outputs; none of them decode combinationally from inputs.

## Structure
- Shared package holds:
  - size encoding constants (SZ_WORD, SZ_HALF, SZ_BYTE)
  - state enum
  - a function computing the byte-enable mask from size and offset
- Sub-module mdr_lane_extract: combinational lane select plus zero/sign extension, parametrised by DATA_W. Used on the read path.
- The FSM, counter and Q register live in the top module.

## Test plan
- Reset: drive clr=0 mid-RD_WAIT -> mem_req=0 immediately, Q=0, no done; after release busy=0.
- Word read: Read, size=00, ack on first wait cycle, mem_rdata=0xDEADBEEF -> Q=0xDEADBEEF two cycles after the Read pulse, done a one-cycle pulse, err=0.
- Byte sign-extend: size=10, addr_lo=2, sext=1, mem_rdata=0x0080_0000 -> Q=0xFFFFFF80. Same with sext=0 -> Q=0x00000080.
- Half store: Q=0x00001234, Write, size=01, addr_lo=2 -> mem_we=1, mem_be=4'b1100, mem_wdata=0x12341234.
- Timeout: Read, mem_ack held 0 -> mem_req high exactly 15 cycles, then done=1, err=1, Q unchanged. The next Read clears err.
- Misaligned/priority:
  - Read, size=01, addr_lo=1 -> no mem_req, done+err the next cycle.
  - Read+MDRin in the same cycle -> read is performed and BusMuxOut is not loaded.
